ddr3_cmd_scheduler: RTL and testbench
=====================================

// Module: ddr3_cmd_scheduler
// PURPOSE
//  Sequences the DDR3 command bus for the board-level memory controller (top level OuterSource).
//  Accepts one write and one read requester, plus an internal periodic refresh, and arbitrates between them.
//  Issues ACT/WR/RD/PRE/REF/NOP on CS/RAS/CAS/WE/Addr_out/BA_out, enforcing bank timing with down-counters.
//  Closed-page policy: every access is ACT -> WR|RD -> PRE(all). All banks are closed whenever the block is in IDLE.
// PARAMETERS
//  ROW_W     15    row address width
//  COL_W     10    column address width (<=10; placed on Addr_out[9:0])
//  BA_W      3     bank address width
//  T_RCD     6     cycles from ACT to WR/RD
//  T_WR_END  14    cycles from WR to PRE (CWL + BL/2 + tWR)
//  T_RD_END  10    cycles from RD to PRE (CL + BL/2 + tRTP margin)
//  T_RP      6     cycles from PRE until the next command
//  T_RFC     110   cycles from REF until the next command
//  T_REFI    1560  refresh interval in cycles (7.8 us at 200 MHz)
// PORTS
//  sysclk     in   1      single controller clock (post differential buffer)
//  RESET_SM   in   1      synchronous reset, active-high
//  init_done  in   1      DRAM init sequence complete; no commands and no refresh counting while 0
//  wr_req     in   1      write request; held high until wr_ack
//  rd_req     in   1      read request; held high until rd_ack
//  row        in   ROW_W  row address, sampled at grant
//  col        in   COL_W  column address, sampled at grant
//  bank       in   BA_W   bank address, sampled at grant
//  wr_ack     out  1      1-cycle pulse in the cycle WR is driven
//  rd_ack     out  1      1-cycle pulse in the cycle RD is driven
//  busy       out  1      high in every state except IDLE
//  ref_ovf    out  1      sticky: T_REFI expired while a refresh was still pending
//  CS,RAS,CAS,WE out 1 each   DDR3 command pins (active-low)
//  Addr_out   out  15     DDR3 address bus
//  BA_out     out  BA_W   DDR3 bank address
// BEHAVIOUR
//  Reset: CS=RAS=CAS=WE=1 (deselect); Addr_out=0; BA_out=0; all other outputs 0.
//    Reset also forces state IDLE, clears counters, the refresh-pending flag, ref_ovf and the rr flag.
//    Reset wins over every other event, including mid-burst.
//  All outputs are registered. A command is valid for exactly 1 cycle; every other cycle drives NOP (CS=0, RAS=CAS=WE=1).
//    During reset and while init_done=0 the pins drive deselect instead of NOP.
//  Command encodings {RAS,CAS,WE}:
//    ACT=011   Addr=row, BA=bank
//    WR=100    Addr[9:0]=col, A10=0, other bits 0
//    RD=101    same address fields as WR
//    PRE=010   A10=1 (all banks)
//    REF=001   Addr=0, BA=0
//  Refresh timer: counts while init_done=1. At count T_REFI-1 it sets ref_pend and wraps to 0.
//    If it expires while ref_pend=1, ref_ovf is set (sticky).
//  States:
//    IDLE -> REF if ref_pend; else ACT if wr_req|rd_req. Requests are evaluated only in IDLE with init_done=1.
//    REF: drive REF and clear ref_pend; wait T_RFC -> IDLE.
//    ACT: drive ACT; latch row/col/bank and the op. Wait T_RCD, then go to WR or RD.
//    WR: drive WR, pulse wr_ack; wait T_WR_END -> PRE.
//    RD: drive RD, pulse rd_ack; wait T_RD_END -> PRE.
//    PRE: drive PRE; wait T_RP -> IDLE.
//  Timing: a wait of N means the next command appears exactly N cycles after the current one (cycle k -> k+N).
//  Arbitration: refresh > requests. Both wr_req and rd_req high -> round-robin via rr (write first after reset).
//    rr toggles only when the granted op's ack pulses.
//  A refresh that comes due mid-access never preempts: the access completes through PRE, then REF is taken from IDLE.
//  Requests dropped before ack are ignored once ACT is issued; the access still completes.
//    A request high at IDLE with init_done=0 is held off, not lost.
//  Minimum IDLE-to-IDLE access time: 1 + T_RCD + T_xx_END + T_RP cycles.
// TESTING
//  1. Reset held 3 cycles, init_done=0 -> CS=RAS=CAS=WE=1, Addr_out=0, busy=0, no acks.
//  2. Write row=0x0012 col=0x0AA bank=2:
//     ACT at k (Addr=0x0012, BA=2); WR at k+6 (Addr=0x00AA, wr_ack=1); PRE at k+20 (Addr[10]=1); busy=0 at k+26.
//  3. Read col=0x0F0: RD at ACT+6 with rd_ack=1; PRE at RD+10.
//  4. wr_req and rd_req held high together -> order W,R,W,R on ACK pulses; each ACT spaced 27/23 cycles apart.
//  5. Refresh comes due during a write -> write finishes PRE; REF issued the cycle after IDLE is re-entered.
//     Next ACT is no earlier than REF+110; ref_ovf stays 0.
//  6. RESET_SM asserted 2 cycles after ACT -> next cycle deselect; WR never issued; no ack.
//     After release with init_done=1 and no requests: NOP; after T_REFI cycles, REF.

Source files
------------

// File: rtl/ddr3_cmd_scheduler_if.sv
// Request and DDR3 command-bus bundle for the command scheduler.
// The master side is the requester/board; the slave side is the scheduler.
interface ddr3_cmd_scheduler_if #(
  parameter int ROW_W = 15,
  parameter int COL_W = 10,
  parameter int BA_W  = 3
);
  logic             init_done;
  logic             wr_req;
  logic             rd_req;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [BA_W-1:0]  bank;
  logic             wr_ack;
  logic             rd_ack;
  logic             busy;
  logic             ref_ovf;
  logic             CS;
  logic             RAS;
  logic             CAS;
  logic             WE;
  logic [14:0]      Addr_out;
  logic [BA_W-1:0]  BA_out;

  modport master (
    output init_done, wr_req, rd_req, row, col, bank,
    input  wr_ack, rd_ack, busy, ref_ovf, CS, RAS, CAS, WE, Addr_out, BA_out
  );

  modport slave (
    input  init_done, wr_req, rd_req, row, col, bank,
    output wr_ack, rd_ack, busy, ref_ovf, CS, RAS, CAS, WE, Addr_out, BA_out
  );
endinterface

// File: rtl/ddr3_cmd_scheduler.sv
// DDR3 command sequencer: closed-page ACT -> WR|RD -> PRE(all) accesses for one
// write and one read requester, plus periodic refresh with priority over both.
// Each wait is a down-counter loaded with N-1 so the next command lands exactly
// N cycles after the current one. All pins are registered.
module ddr3_cmd_scheduler #(
  parameter int ROW_W    = 15,
  parameter int COL_W    = 10,
  parameter int BA_W     = 3,
  parameter int T_RCD    = 6,
  parameter int T_WR_END = 14,
  parameter int T_RD_END = 10,
  parameter int T_RP     = 6,
  parameter int T_RFC    = 110,
  parameter int T_REFI   = 1560
) (
  input  logic                sysclk,
  input  logic                RESET_SM,
  ddr3_cmd_scheduler_if.slave bus
);
  localparam int CNT_W  = 8;
  localparam int REFI_W = $clog2(T_REFI);

  // {RAS,CAS,WE} encodings; CS is driven separately
  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_ACT = 3'b011;
  localparam logic [2:0] CMD_WR  = 3'b100;
  localparam logic [2:0] CMD_RD  = 3'b101;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;

  typedef enum logic [2:0] {S_IDLE, S_REF, S_ACT, S_WR, S_RD, S_PRE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [REFI_W-1:0]  refi_cnt;
  logic               ref_pend;
  logic               rr;
  logic               op_wr;
  logic [COL_W-1:0]   col_q;
  logic [BA_W-1:0]    ba_q;
  logic               refi_exp;
  logic               ref_take;
  logic               grant_wr;
  logic               cnt_done;

  assign refi_exp = bus.init_done && (refi_cnt == REFI_W'(T_REFI - 1));
  assign ref_take = (state == S_IDLE) && bus.init_done && ref_pend;
  // rr=0 favours the writer when both requesters are asking
  assign grant_wr = bus.wr_req && (!bus.rd_req || !rr);
  assign cnt_done = (cnt == '0);

  // Refresh interval timer, pending flag and sticky overflow
  always_ff @(posedge sysclk) begin
    if (RESET_SM) begin
      refi_cnt    <= '0;
      ref_pend    <= 1'b0;
      bus.ref_ovf <= 1'b0;
    end else begin
      if (bus.init_done)
        refi_cnt <= refi_exp ? '0 : refi_cnt + 1'b1;
      if (refi_exp) begin
        ref_pend <= 1'b1;
        if (ref_pend && !ref_take)
          bus.ref_ovf <= 1'b1;
      end else if (ref_take) begin
        ref_pend <= 1'b0;
      end
    end
  end

  // Column and bank captured at grant; row is only needed on the ACT cycle itself
  always_ff @(posedge sysclk) begin
    if (state == S_IDLE) begin
      col_q <= bus.col;
      ba_q  <= bus.bank;
    end
  end

  // Command FSM with registered pins; idle cycles drive NOP, or deselect before init
  always_ff @(posedge sysclk) begin
    if (RESET_SM) begin
      state                     <= S_IDLE;
      cnt                       <= '0;
      rr                        <= 1'b0;
      op_wr                     <= 1'b0;
      bus.busy                  <= 1'b0;
      bus.CS                    <= 1'b1;
      {bus.RAS, bus.CAS, bus.WE} <= CMD_NOP;
      bus.Addr_out              <= '0;
      bus.BA_out                <= '0;
      bus.wr_ack                <= 1'b0;
      bus.rd_ack                <= 1'b0;
    end else begin
      bus.CS                    <= ~bus.init_done;
      {bus.RAS, bus.CAS, bus.WE} <= CMD_NOP;
      bus.Addr_out              <= '0;
      bus.BA_out                <= '0;
      bus.wr_ack                <= 1'b0;
      bus.rd_ack                <= 1'b0;
      if (!cnt_done)
        cnt <= cnt - 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.init_done) begin
            if (ref_pend) begin
              state                     <= S_REF;
              cnt                       <= CNT_W'(T_RFC - 1);
              bus.busy                  <= 1'b1;
              bus.CS                    <= 1'b0;
              {bus.RAS, bus.CAS, bus.WE} <= CMD_REF;
            end else if (bus.wr_req || bus.rd_req) begin
              state                     <= S_ACT;
              cnt                       <= CNT_W'(T_RCD - 1);
              op_wr                     <= grant_wr;
              bus.busy                  <= 1'b1;
              bus.CS                    <= 1'b0;
              {bus.RAS, bus.CAS, bus.WE} <= CMD_ACT;
              bus.Addr_out              <= 15'(bus.row);
              bus.BA_out                <= bus.bank;
            end
          end
        end
        S_REF: begin
          if (cnt_done) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        end
        S_ACT: begin
          if (cnt_done) begin
            bus.CS       <= 1'b0;
            bus.Addr_out <= 15'(col_q);
            bus.BA_out   <= ba_q;
            rr           <= ~rr;
            if (op_wr) begin
              state                     <= S_WR;
              cnt                       <= CNT_W'(T_WR_END - 1);
              {bus.RAS, bus.CAS, bus.WE} <= CMD_WR;
              bus.wr_ack                <= 1'b1;
            end else begin
              state                     <= S_RD;
              cnt                       <= CNT_W'(T_RD_END - 1);
              {bus.RAS, bus.CAS, bus.WE} <= CMD_RD;
              bus.rd_ack                <= 1'b1;
            end
          end
        end
        S_WR, S_RD: begin
          if (cnt_done) begin
            state                     <= S_PRE;
            cnt                       <= CNT_W'(T_RP - 1);
            bus.CS                    <= 1'b0;
            {bus.RAS, bus.CAS, bus.WE} <= CMD_PRE;
            bus.Addr_out              <= 15'h0400;
          end
        end
        S_PRE: begin
          if (cnt_done) begin
            state    <= S_IDLE;
            bus.busy <= 1'b0;
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ddr3_cmd_scheduler.sv
// Bench for ddr3_cmd_scheduler: stimulus pushes the expected command stream
// (command, address, acks, spacing to the previous command) into a queue and a
// monitor pops and compares every command seen on the DDR3 pins.
module tb_ddr3_cmd_scheduler;
  localparam int ROW_W = 15, COL_W = 10, BA_W = 3;
  localparam int T_RCD = 6, T_WR_END = 14, T_RD_END = 10, T_RP = 6;
  localparam int T_RFC = 110, T_REFI = 1560;

  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_WR = 3'b100;
  localparam logic [2:0] C_RD  = 3'b101, C_PRE = 3'b010, C_REF = 3'b001;

  localparam int W_WRACK = 0, W_RDACK = 1, W_IDLE = 2, W_ACT = 3, W_ANYACK = 4;

  typedef struct {
    logic [2:0]      cmd;
    logic [14:0]     addr;
    logic [BA_W-1:0] ba;
    bit              chk_ba;
    bit              wack;
    bit              rack;
    int              gap;
    bit              gap_min;
  } exp_t;

  logic sysclk = 1'b0;
  logic RESET_SM;

  ddr3_cmd_scheduler_if #(.ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W)) bus();

  ddr3_cmd_scheduler #(
    .ROW_W(ROW_W), .COL_W(COL_W), .BA_W(BA_W), .T_RCD(T_RCD),
    .T_WR_END(T_WR_END), .T_RD_END(T_RD_END), .T_RP(T_RP),
    .T_RFC(T_RFC), .T_REFI(T_REFI)
  ) dut (
    .sysclk  (sysclk),
    .RESET_SM(RESET_SM),
    .bus     (bus)
  );

  always #5 sysclk = ~sysclk;

  exp_t expq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   last_cmd = 0;
  bit   m_rr  = 1'b0;

  task automatic chk(input string name, input longint act, input longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push(input logic [2:0] c, input logic [14:0] a,
                               input logic [BA_W-1:0] b, input bit cb,
                               input bit w, input bit r, input int g, input bit gm);
    exp_t e;
    e.cmd = c; e.addr = a; e.ba = b; e.chk_ba = cb;
    e.wack = w; e.rack = r; e.gap = g; e.gap_min = gm;
    expq.push_back(e);
  endfunction

  // Which requester wins at grant: lone requester, else alternate starting with write
  function automatic bit pick_wr(input bit w, input bit r);
    return w && (!r || !m_rr);
  endfunction

  // One closed-page access as seen on the pins
  function automatic void model_access(input bit is_wr, input logic [ROW_W-1:0] r,
                                       input logic [COL_W-1:0] c, input logic [BA_W-1:0] b,
                                       input int act_gap, input bit act_min);
    push(C_ACT, 15'(r), b, 1'b1, 1'b0, 1'b0, act_gap, act_min);
    push(is_wr ? C_WR : C_RD, 15'(c), '0, 1'b0, is_wr, !is_wr, T_RCD, 1'b0);
    push(C_PRE, 15'h0400, '0, 1'b0, 1'b0, 1'b0, is_wr ? T_WR_END : T_RD_END, 1'b0);
    m_rr = ~m_rr;
  endfunction

  function automatic bit cond(input int which);
    case (which)
      W_WRACK:  return bus.wr_ack;
      W_RDACK:  return bus.rd_ack;
      W_IDLE:   return !bus.busy;
      W_ACT:    return !bus.CS && ({bus.RAS, bus.CAS, bus.WE} == C_ACT);
      default:  return bus.wr_ack || bus.rd_ack;
    endcase
  endfunction

  task automatic wait_for(input int which, input int bound, input string name, output int n);
    bit ok;
    ok = 1'b0;
    n  = 0;
    for (int i = 1; i <= bound; i++) begin
      @(negedge sysclk);
      if (cond(which)) begin
        ok = 1'b1;
        n  = i;
        break;
      end
    end
    if (!ok) chk({"timeout_", name}, 0, 1);
  endtask

  // Monitor: every non-NOP command must match the head of the expected queue
  initial begin : monitor
    exp_t e;
    logic [2:0] c;
    forever begin
      @(negedge sysclk);
      cyc++;
      c = {bus.RAS, bus.CAS, bus.WE};
      if (!bus.CS && c != C_NOP) begin
        if (expq.size() == 0) begin
          chk("unexpected_cmd", c, C_NOP);
        end else begin
          e = expq.pop_front();
          chk("cmd", c, e.cmd);
          chk("addr", bus.Addr_out, e.addr);
          if (e.chk_ba) chk("ba", bus.BA_out, e.ba);
          chk("wr_ack", bus.wr_ack, e.wack);
          chk("rd_ack", bus.rd_ack, e.rack);
          if (e.gap >= 0) begin
            if (e.gap_min) chk("gap_min_ok", (cyc - last_cmd) >= e.gap, 1);
            else           chk("gap", cyc - last_cmd, e.gap);
          end
        end
        last_cmd = cyc;
      end else if (bus.wr_ack || bus.rd_ack) begin
        chk("stray_ack", {bus.wr_ack, bus.rd_ack}, 0);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n, start_cyc, ref_n;
    bit w, r, g;
    logic [ROW_W-1:0] rrow;
    logic [COL_W-1:0] rcol;
    logic [BA_W-1:0]  rba;

    RESET_SM = 1'b1;
    bus.init_done = 1'b0;
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.row = '0;
    bus.col = '0;
    bus.bank = '0;

    // Reset with init_done low: deselect, quiet outputs
    repeat (3) @(negedge sysclk);
    chk("rst_cs", bus.CS, 1);
    chk("rst_cmd", {bus.RAS, bus.CAS, bus.WE}, C_NOP);
    chk("rst_addr", bus.Addr_out, 0);
    chk("rst_ba", bus.BA_out, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_acks", {bus.wr_ack, bus.rd_ack}, 0);
    chk("rst_ovf", bus.ref_ovf, 0);
    RESET_SM = 1'b0;
    m_rr = 1'b0;

    // Write request held off while init_done=0, then granted
    bus.row = 15'h0012; bus.col = 10'h0AA; bus.bank = 3'd2;
    bus.wr_req = 1'b1;
    model_access(1'b1, 15'h0012, 10'h0AA, 3'd2, -1, 1'b0);
    repeat (4) begin
      @(negedge sysclk);
      chk("held_off_cs", bus.CS, 1);
    end
    bus.init_done = 1'b1;
    start_cyc = cyc;
    wait_for(W_ACT, 5, "act1", n);
    chk("busy_after_act", bus.busy, 1);
    wait_for(W_WRACK, 20, "wr_ack1", n);
    chk("wr_ack_latency", n, T_RCD);
    bus.wr_req = 1'b0;
    repeat (19) @(negedge sysclk);
    chk("busy_k25", bus.busy, 1);
    @(negedge sysclk);
    chk("busy_k26", bus.busy, 0);

    // Single read
    bus.row = 15'h1234; bus.col = 10'h0F0; bus.bank = 3'd5;
    model_access(1'b0, 15'h1234, 10'h0F0, 3'd5, -1, 1'b0);
    bus.rd_req = 1'b1;
    wait_for(W_RDACK, 30, "rd_ack1", n);
    bus.rd_req = 1'b0;
    wait_for(W_IDLE, 30, "idle_rd", n);

    // Both requesters held: alternating grants, back-to-back accesses
    bus.row = 15'h7ABC; bus.col = 10'h155; bus.bank = 3'd7;
    for (int i = 0; i < 4; i++) begin
      g = pick_wr(1'b1, 1'b1);
      model_access(g, 15'h7ABC, 10'h155, 3'd7, (i == 0) ? -1 : T_RP + 1, 1'b0);
    end
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 4; i++) wait_for(W_ANYACK, 40, "rr_ack", n);
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    wait_for(W_IDLE, 40, "idle_rr", n);

    // Randomized traffic, kept inside the first refresh interval
    while (cyc - start_cyc < 1250) begin
      repeat ($urandom_range(0, 3)) @(negedge sysclk);
      case ($urandom_range(0, 2))
        0:       begin w = 1'b1; r = 1'b0; end
        1:       begin w = 1'b0; r = 1'b1; end
        default: begin w = 1'b1; r = 1'b1; end
      endcase
      rrow = 15'($urandom); rcol = 10'($urandom); rba = 3'($urandom);
      bus.row = rrow; bus.col = rcol; bus.bank = rba;
      g = pick_wr(w, r);
      model_access(g, rrow, rcol, rba, -1, 1'b0);
      bus.wr_req = w;
      bus.rd_req = r;
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge sysclk);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
      end
      wait_for(g ? W_WRACK : W_RDACK, 40, "rand_ack", n);
      bus.wr_req = 1'b0;
      bus.rd_req = 1'b0;
      wait_for(W_IDLE, 40, "rand_idle", n);
    end

    // Refresh comes due in the middle of a write; a read waits behind it
    RESET_SM = 1'b1;
    repeat (2) @(negedge sysclk);
    m_rr = 1'b0;
    RESET_SM = 1'b0;
    repeat (T_REFI - 15) @(negedge sysclk);
    bus.row = 15'h0333; bus.col = 10'h011; bus.bank = 3'd1;
    model_access(1'b1, 15'h0333, 10'h011, 3'd1, -1, 1'b0);
    push(C_REF, 15'h0000, '0, 1'b1, 1'b0, 1'b0, T_RP + 1, 1'b0);
    model_access(1'b0, 15'h0444, 10'h022, 3'd6, T_RFC, 1'b1);
    bus.wr_req = 1'b1;
    wait_for(W_WRACK, 30, "ref_wr_ack", n);
    bus.wr_req = 1'b0;
    bus.row = 15'h0444; bus.col = 10'h022; bus.bank = 3'd6;
    bus.rd_req = 1'b1;
    wait_for(W_RDACK, 200, "ref_rd_ack", n);
    bus.rd_req = 1'b0;
    wait_for(W_IDLE, 40, "ref_idle", n);
    chk("ref_ovf_clear", bus.ref_ovf, 0);

    // Reset two cycles after ACT aborts the access
    bus.row = 15'h0055; bus.col = 10'h3FF; bus.bank = 3'd3;
    push(C_ACT, 15'h0055, 3'd3, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    bus.wr_req = 1'b1;
    wait_for(W_ACT, 5, "abort_act", n);
    @(negedge sysclk);
    @(negedge sysclk);
    RESET_SM = 1'b1;
    bus.wr_req = 1'b0;
    @(negedge sysclk);
    chk("abort_cs", bus.CS, 1);
    chk("abort_cmd", {bus.RAS, bus.CAS, bus.WE}, C_NOP);
    chk("abort_addr", bus.Addr_out, 0);
    chk("abort_wr_ack", bus.wr_ack, 0);
    chk("abort_busy", bus.busy, 0);
    @(negedge sysclk);
    RESET_SM = 1'b0;
    m_rr = 1'b0;
    push(C_REF, 15'h0000, '0, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    ref_n = -1;
    for (int i = 1; i <= T_REFI + 10; i++) begin
      @(negedge sysclk);
      if (i == 5) begin
        chk("post_rst_nop_cs", bus.CS, 0);
        chk("post_rst_nop_cmd", {bus.RAS, bus.CAS, bus.WE}, C_NOP);
      end
      if (!bus.CS && {bus.RAS, bus.CAS, bus.WE} == C_REF) begin
        ref_n = i;
        break;
      end
    end
    chk("ref_after_release_window", (ref_n >= T_REFI) && (ref_n <= T_REFI + 2), 1);

    repeat (3) @(negedge sysclk);
    chk("expected_queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
